// File: rtl/score_pkg.sv
// Shared types and widths for the score counter slice.
// Game-state and hold-phase encodings used by score_counter.
package score_pkg;

  localparam int SCORE_W = 8;

  typedef enum logic [1:0] {
    GS_IDLE      = 2'd0,
    GS_PLAYING   = 2'd1,
    GS_GAME_OVER = 2'd2
  } game_state_e;

  typedef enum logic [1:0] {
    HP_NONE    = 2'd0,
    HP_INITIAL = 2'd1,
    HP_REPEAT  = 2'd2
  } hold_phase_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser plus debouncer for the raw move button.
// Ports: i_clk, i_rst_n (sync, active-low), i_btn (raw) ->
//   o_level (debounced), o_press / o_release (1-cycle pulses).
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEBOUNCE_W      = 18
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEBOUNCE_W-1:0]  cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_btn};
      o_press   <= 1'b0;
      o_release <= 1'b0;
      if (synced == o_level) begin
        cnt_q <= '0;
      end else if (cnt_q == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
        // Edge pulses are registered alongside the level change.
        o_level   <= synced;
        o_press   <= synced;
        o_release <= ~synced;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_counter.sv
// Game FSM, press/auto-repeat step counter and frame-latched score.
// Ports: i_clk, i_rst_n, i_move_btn, i_frame_tick, i_start, i_collision
//   -> o_score, o_game_over, o_step, o_high_score.
// Optional high-score register: define SCORE_HIGH_SCORE_EN.
module score_counter
  import score_pkg::*;
#(
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 250000,
  parameter int DEBOUNCE_W           = 18,
  parameter int INITIAL_DELAY_FRAMES = 20,
  parameter int REPEAT_FRAMES        = 8,
  parameter int SCORE_MAX            = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_move_btn,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_collision,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_game_over,
  output logic               o_step,
  output logic [SCORE_W-1:0] o_high_score
);

  localparam int FRAME_MAX =
    (INITIAL_DELAY_FRAMES > REPEAT_FRAMES) ?
    INITIAL_DELAY_FRAMES : REPEAT_FRAMES;
  localparam int FRAME_W = $clog2(FRAME_MAX + 1);

  game_state_e        state_q, state_d;
  hold_phase_e        phase_q, phase_d;
  logic [FRAME_W-1:0] frame_q, frame_d, frame_nxt;
  logic [SCORE_W-1:0] count_q;
  logic               step_req;
  logic               btn_level, btn_press, btn_release;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEBOUNCE_W     (DEBOUNCE_W)
  ) u_btn (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_move_btn),
    .o_level  (btn_level),
    .o_press  (btn_press),
    .o_release(btn_release)
  );

  assign frame_nxt = frame_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    frame_d  = frame_q;
    step_req = 1'b0;
    unique case (state_q)
      GS_PLAYING: begin
        if (btn_press) begin
          step_req = 1'b1;
          frame_d  = '0;
          phase_d  = HP_INITIAL;
        end else if (btn_release) begin
          frame_d = '0;
          phase_d = HP_NONE;
        end else if (i_frame_tick && btn_level &&
                     phase_q != HP_NONE) begin
          if (phase_q == HP_INITIAL &&
              frame_nxt == FRAME_W'(INITIAL_DELAY_FRAMES)) begin
            step_req = 1'b1;
            frame_d  = '0;
            phase_d  = HP_REPEAT;
          end else if (phase_q == HP_REPEAT &&
                       frame_nxt == FRAME_W'(REPEAT_FRAMES)) begin
            step_req = 1'b1;
            frame_d  = '0;
          end else begin
            frame_d = frame_nxt;
          end
        end
        if (i_collision) begin
          state_d = GS_GAME_OVER;
          phase_d = HP_NONE;
          frame_d = '0;
        end
      end
      GS_IDLE, GS_GAME_OVER: begin
        // Phase stays NONE outside play, so a button already held
        // on entry needs a fresh press before it can step.
        phase_d = HP_NONE;
        frame_d = '0;
        if (i_start) state_d = GS_PLAYING;
      end
      default: begin
        state_d = GS_IDLE;
        phase_d = HP_NONE;
        frame_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= GS_IDLE;
      phase_q     <= HP_NONE;
      frame_q     <= '0;
      count_q     <= '0;
      o_score     <= '0;
      o_game_over <= 1'b0;
      o_step      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      o_game_over <= (state_d == GS_GAME_OVER);
      o_step      <= 1'b0;
      if (state_q != GS_PLAYING && i_start) begin
        count_q <= '0;
      end else if (step_req && !i_collision &&
                   count_q < SCORE_W'(SCORE_MAX)) begin
        count_q <= count_q + 1'b1;
        o_step  <= 1'b1;
      end
      // Pre-step value on a coincident tick; step shows next frame.
      if (i_frame_tick) o_score <= count_q;
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      high_q <= '0;
    end else if (state_q == GS_PLAYING &&
                 state_d == GS_GAME_OVER &&
                 count_q > high_q) begin
      high_q <= count_q;
    end
  end

  assign o_high_score = high_q;
`else
  assign o_high_score = '0;
`endif

endmodule
